// File: rtl/w_stage_grf_pkg.sv
// Shared MIPS decode definitions: opcode/funct constants, write-source
// encoding and the writeback decode reused by the D-stage hazard unit.
package mips_defs;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_DM  = 2'd1,
        SRC_PC8 = 2'd2
    } wsrc_e;

    typedef struct packed {
        logic       wr;
        logic [4:0] dest;
        wsrc_e      src;
    } wb_dec_t;

    // Writeback decode: does the instruction write a GPR, which one, and
    // from which source. The $0 suppression is applied by the caller.
    function automatic wb_dec_t decode_wb(input logic [31:0] ir, input logic [4:0] ra_reg);
        wb_dec_t d;
        d.wr   = 1'b0;
        d.dest = 5'd0;
        d.src  = SRC_ALU;
        case (ir[31:26])
            OP_SPECIAL: begin
                case (ir[5:0])
                    FN_ADDU, FN_SUBU, FN_SLL: begin
                        d.wr   = 1'b1;
                        d.dest = ir[15:11];
                        d.src  = SRC_ALU;
                    end
                    FN_JALR: begin
                        d.wr   = 1'b1;
                        d.dest = ir[15:11];
                        d.src  = SRC_PC8;
                    end
                    FN_JR: begin
                        d.wr   = 1'b0;
                    end
                    default: begin
                        d.wr   = 1'b0;
                    end
                endcase
            end
            OP_ORI, OP_LUI: begin
                d.wr   = 1'b1;
                d.dest = ir[20:16];
                d.src  = SRC_ALU;
            end
            OP_LW: begin
                d.wr   = 1'b1;
                d.dest = ir[20:16];
                d.src  = SRC_DM;
            end
            OP_JAL: begin
                d.wr   = 1'b1;
                d.dest = ra_reg;
                d.src  = SRC_PC8;
            end
            OP_SW, OP_BEQ, OP_J: begin
                d.wr   = 1'b0;
            end
            default: begin
                d.wr   = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/w_stage_grf_core.sv
// grf_core: 32x32 register file with async clear, hard-wired $0 and
// write-to-read bypass on both combinational read ports.
module grf_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_a1,
    input  logic [4:0]  i_a2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);

    logic [31:0] r_regs [32];

    // Register array: cleared immediately by reset, one write per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read port 1: $0 reads zero, otherwise bypass a same-cycle write.
    always_comb begin
        o_rd1 = 32'h0;
        if (i_a1 == 5'd0) begin
            o_rd1 = 32'h0;
        end else if (i_we && (i_a1 == i_waddr)) begin
            o_rd1 = i_wdata;
        end else begin
            o_rd1 = r_regs[i_a1];
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        o_rd2 = 32'h0;
        if (i_a2 == 5'd0) begin
            o_rd2 = 32'h0;
        end else if (i_we && (i_a2 == i_waddr)) begin
            o_rd2 = i_wdata;
        end else begin
            o_rd2 = r_regs[i_a2];
        end
    end

endmodule

// File: rtl/w_stage_grf.sv
// Writeback stage: decodes the W-stage instruction, selects the write
// data, drives the register file and counts retired instructions.
module w_stage_grf
    import mips_defs::*;
#(
    parameter logic [4:0] RA_REG = 5'd31,
    parameter int         CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IR_W,
    input  logic [31:0]      PC8_W,
    input  logic [31:0]      AO_W,
    input  logic [31:0]      DO_W,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    output logic [31:0]      RD1,
    output logic [31:0]      RD2,
    output logic             W_we,
    output logic [4:0]       W_addr,
    output logic [31:0]      W_data,
    output logic [CNT_W-1:0] retired
);

    wb_dec_t          w_dec;
    logic [CNT_W-1:0] r_retired;

    assign w_dec = decode_wb(IR_W, RA_REG);

    // Writeback triple; everything held at zero while reset is asserted
    // so the register-file bypass cannot leak data during reset.
    always_comb begin
        W_we   = 1'b0;
        W_addr = 5'd0;
        W_data = 32'h0;
        if (reset) begin
            case (w_dec.src)
                SRC_ALU: W_data = AO_W;
                SRC_DM:  W_data = DO_W;
                SRC_PC8: W_data = PC8_W;
                default: W_data = 32'h0;
            endcase
            if (w_dec.wr && (w_dec.dest != 5'd0)) begin
                W_we   = 1'b1;
                W_addr = w_dec.dest;
            end else begin
                W_we   = 1'b0;
                W_addr = 5'd0;
            end
        end else begin
            W_data = 32'h0;
        end
    end

    // Retired counter: every non-bubble instruction, wrapping freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired <= {CNT_W{1'b0}};
        end else if (IR_W != 32'h0) begin
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign retired = r_retired;

    grf_core u_grf (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (W_we),
        .i_waddr (W_addr),
        .i_wdata (W_data),
        .i_a1    (A1),
        .i_a2    (A2),
        .o_rd1   (RD1),
        .o_rd2   (RD2)
    );

endmodule

// File: tb/tb_w_stage_grf.sv
// Bench for w_stage_grf: behavioural register-file model checked every
// negative clock edge, directed scenarios with literal expectations, then
// randomized instruction traffic with occasional mid-cycle resets.
module tb_w_stage_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_W, PC8_W, AO_W, DO_W;
    logic [4:0]  A1, A2;
    logic [31:0] RD1, RD2, W_data;
    logic        W_we;
    logic [4:0]  W_addr;
    logic [3:0]  retired;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_reg [32];
    int          m_ret;

    always #5 clk = ~clk;

    w_stage_grf #(.RA_REG(5'd31), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .IR_W(IR_W), .PC8_W(PC8_W), .AO_W(AO_W),
        .DO_W(DO_W), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .W_we(W_we),
        .W_addr(W_addr), .W_data(W_data), .retired(retired)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // What the W stage should commit, straight from the ISA table.
    task automatic model_wb(output bit we, output logic [4:0] addr, output logic [31:0] data);
        int op, fn, dst;
        op = int'(IR_W[31:26]);
        fn = int'(IR_W[5:0]);
        dst = -1;
        data = 32'h0;
        if (op == 0 && (fn == 33 || fn == 35 || fn == 0)) begin dst = int'(IR_W[15:11]); data = AO_W; end
        else if (op == 0 && fn == 9) begin dst = int'(IR_W[15:11]); data = PC8_W; end
        else if (op == 13 || op == 15) begin dst = int'(IR_W[20:16]); data = AO_W; end
        else if (op == 35) begin dst = int'(IR_W[20:16]); data = DO_W; end
        else if (op == 3) begin dst = 31; data = PC8_W; end
        we = (reset === 1'b1) && (dst > 0);
        addr = we ? dst[4:0] : 5'd0;
        if (reset !== 1'b1) data = 32'h0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit we,
                                           input logic [4:0] addr, input logic [31:0] data);
        if (a == 5'd0) return 32'h0;
        if (we && a == addr) return data;
        return m_reg[a];
    endfunction

    // Model state update on each rising edge.
    always @(posedge clk) begin : model_upd
        bit          e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        if (reset === 1'b1) begin
            model_wb(e_we, e_addr, e_data);
            if (e_we) m_reg[e_addr] = e_data;
            if (IR_W != 32'h0) m_ret++;
        end
    end

    // Model reset clears everything immediately.
    always @(negedge reset) begin
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_ret = 0;
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin : cmp
        bit          e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        model_wb(e_we, e_addr, e_data);
        chk("W_we", {31'h0, W_we}, {31'h0, e_we});
        chk("W_addr", {27'h0, W_addr}, {27'h0, e_addr});
        if (e_we || reset !== 1'b1) chk("W_data", W_data, e_data);
        chk("RD1", RD1, exp_rd(A1, e_we, e_addr, e_data));
        chk("RD2", RD2, exp_rd(A2, e_we, e_addr, e_data));
        chk("retired", {28'h0, retired}, 32'(m_ret % 16));
    end

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_ret = 0;
        reset = 1'b0;
        IR_W = rtype(6'b100001, 5'd1, 5'd2, 5'd3);
        AO_W = 32'd5; PC8_W = 32'h0; DO_W = 32'h0;
        A1 = 5'd3; A2 = 5'd0;

        // Reset holds everything at zero despite an active addu.
        repeat (2) step();
        look();
        chk("rst_rd1", RD1, 32'h0);
        chk("rst_we", {31'h0, W_we}, 32'h0);
        chk("rst_retired", {28'h0, retired}, 32'h0);
        reset = 1'b1;
        step();
        IR_W = 32'h0;
        look();
        chk("rel_reg3", RD1, 32'd5);
        chk("rel_retired", {28'h0, retired}, 32'd1);

        // Write-source selection.
        step();
        IR_W = itype(6'b100011, 5'd0, 5'd8, 16'h0); DO_W = 32'hDEADBEEF; AO_W = 32'h1234;
        step();
        IR_W = {6'b000011, 26'h0000C03}; PC8_W = 32'h0000300C;
        step();
        IR_W = itype(6'b001101, 5'd0, 5'd9, 16'hFFFF); AO_W = 32'h0000FFFF;
        step();
        IR_W = 32'h0; A1 = 5'd8; A2 = 5'd31;
        look();
        chk("lw_reg8", RD1, 32'hDEADBEEF);
        chk("jal_reg31", RD2, 32'h0000300C);
        A1 = 5'd9;
        #1;
        chk("ori_reg9", RD1, 32'h0000FFFF);

        // $0 writes and non-writing instructions.
        step();
        IR_W = rtype(6'b100001, 5'd1, 5'd2, 5'd0); AO_W = 32'd7; A1 = 5'd0;
        look();
        chk("zero_we", {31'h0, W_we}, 32'h0);
        chk("zero_rd1", RD1, 32'h0);
        step();
        IR_W = itype(6'b101011, 5'd0, 5'd8, 16'h0);
        step();
        IR_W = itype(6'b000100, 5'd1, 5'd2, 16'h1);
        step();
        IR_W = 32'h0; A1 = 5'd8;
        step();
        look();
        chk("nowrite_retired", {28'h0, retired}, 32'd7);
        chk("nowrite_reg8", RD1, 32'hDEADBEEF);

        // Same-cycle bypass on both ports.
        step();
        IR_W = rtype(6'b100001, 5'd1, 5'd2, 5'd5); AO_W = 32'hA5A5A5A5; A1 = 5'd5; A2 = 5'd5;
        look();
        chk("byp_rd1", RD1, 32'hA5A5A5A5);
        chk("byp_rd2", RD2, 32'hA5A5A5A5);
        step();
        IR_W = 32'h0;
        look();
        chk("byp_stored", RD1, 32'hA5A5A5A5);

        // Reset between edges kills state; pending write waits for release.
        step();
        IR_W = itype(6'b001101, 5'd0, 5'd4, 16'h1); AO_W = 32'd1;
        step();
        IR_W = 32'h0; A1 = 5'd4;
        look();
        chk("mid_reg4", RD1, 32'd1);
        IR_W = itype(6'b001101, 5'd0, 5'd4, 16'h9); AO_W = 32'd9;
        reset = 1'b0;
        #1;
        chk("mid_rst_rd1", RD1, 32'h0);
        chk("mid_rst_retired", {28'h0, retired}, 32'h0);
        look();
        chk("mid_held_rd1", RD1, 32'h0);
        reset = 1'b1;
        step();
        IR_W = 32'h0;
        look();
        chk("mid_after_rel", RD1, 32'd9);
        chk("mid_after_ret", {28'h0, retired}, 32'd1);

        // Counter wrap with a 4-bit counter.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            IR_W = itype(6'b001101, 5'd0, 5'd10, 16'(i)); AO_W = 32'(i);
            step();
        end
        IR_W = 32'h0;
        look();
        chk("wrap_full", {28'h0, retired}, 32'd15);
        IR_W = itype(6'b101011, 5'd0, 5'd10, 16'h0);
        step();
        IR_W = 32'h0;
        look();
        chk("wrap_zero", {28'h0, retired}, 32'd0);

        // Randomized traffic.
        step();
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rs, rt, rd;
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            AO_W = $urandom; DO_W = $urandom; PC8_W = $urandom;
            case ($urandom_range(0, 13))
                0:  IR_W = rtype(6'b100001, rs, rt, rd);
                1:  IR_W = rtype(6'b100011, rs, rt, rd);
                2:  IR_W = rtype(6'b000000, rs, rt, rd);
                3:  IR_W = rtype(6'b001001, rs, rt, rd);
                4:  IR_W = itype(6'b001101, rs, rt, 16'($urandom));
                5:  IR_W = itype(6'b001111, rs, rt, 16'($urandom));
                6:  IR_W = itype(6'b100011, rs, rt, 16'($urandom));
                7:  IR_W = {6'b000011, 26'($urandom)};
                8:  IR_W = itype(6'b101011, rs, rt, 16'($urandom));
                9:  IR_W = itype(6'b000100, rs, rt, 16'($urandom));
                10: IR_W = rtype(6'b001000, rs, rt, rd);
                11: IR_W = $urandom;
                12: IR_W = {6'b000010, 26'($urandom)};
                default: IR_W = 32'h0;
            endcase
            A1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
            A2 = ($urandom_range(0, 3) == 0) ? rt : 5'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                #2;
                reset = 1'b0;
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/w_stage_grf.md
Name: w_stage_grf

Overview:
- Writeback stage plus general register file of the 5-stage MIPS pipeline, sitting directly downstream of the W pipeline register.
- Consumes IR_W, PC8_W, AO_W and DO_W; decodes the destination register and the write-data source; commits the result to a 32x32 register file.
- Serves the two combinational read ports used by the D stage, with internal write-to-read bypass.
- Exports the writeback triple for the hazard/forwarding unit and keeps a retired-instruction counter.

Parameters:
- RA_REG, 5'd31, destination register index for jal.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears state immediately).
- IR_W  input  32  instruction in W stage; 32'h0 denotes a bubble.
- PC8_W  input  32  PC+8 of that instruction.
- AO_W  input  32  ALU result carried from M.
- DO_W  input  32  data-memory read data carried from M.
- A1  input  5  D-stage read address for rs.
- A2  input  5  D-stage read address for rt.
- RD1  output  32  read data for A1.
- RD2  output  32  read data for A2.
- W_we  output  1  writeback enable, to hazard unit.
- W_addr  output  5  writeback destination; 0 when W_we==0.
- W_data  output  32  writeback data.
- retired  output  CNT_W  count of non-bubble instructions committed.

Behaviour:
- Decode, combinational from IR_W:
  - op=IR_W[31:26], funct=IR_W[5:0].
  - op=000000 with funct addu(100001), subu(100011) or sll(000000): dest=rd, src=AO_W.
  - op=000000 with funct jalr(001001): dest=rd, src=PC8_W.
  - ori(001101), lui(001111): dest=rt, src=AO_W.
  - lw(100011): dest=rt, src=DO_W.
  - jal(000011): dest=RA_REG, src=PC8_W.
  - Every other opcode or funct, including sw, beq, j and jr: W_we=0.
- W_we = decoded write && dest!=0. Writes to $0 are suppressed, so W_addr=0 and W_we=0 in that case.
- Register file: 32 entries of 32 bits. On a rising clk edge with W_we=1, reg[W_addr] <= W_data. Single write port, one cycle write latency.
- Reads are combinational. A read of address 0 returns 32'h0.
- Bypass: if W_we=1 and A1==W_addr, RD1=W_data (same for A2/RD2). The D stage therefore sees this cycle's writeback without an extra forwarding path.
- retired increments by 1 on each rising edge where IR_W!=32'h0. It wraps modulo 2^CNT_W with no saturation and no flag.
- Reset (reset==0, asynchronous):
  - All 32 registers and retired go to 0 at once, regardless of clk.
  - RD1 and RD2 read 0 at any address while reset is held, since the bypass is blocked because W_we is forced to 0.
  - W_we=0, W_addr=0, W_data=0 while reset is held.
- Reset asserted in the middle of a write cycle: the reset wins and no write survives.
- Deassertion: the first write can happen on the first rising edge after reset returns to 1.
- Simultaneous write and read of the same register: the bypass value is returned, and the stored value matches it after the edge.
- A1==A2==W_addr: both read ports return W_data.

Decomposition:
- Shared package (mips_defs): opcode constants (OP_SPECIAL, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL), funct constants (FN_ADDU, FN_SUBU, FN_SLL, FN_JR, FN_JALR), and the write-source enum {SRC_ALU, SRC_DM, SRC_PC8}. The same decode is reused by the D-stage hazard unit.
- One sub-module, grf_core: register array, async clear, $0 rule, bypassed read ports.
- The top level holds the decode, the data mux and the retired counter.

Test Plan:
- Reset clears state: hold reset=0, drive IR_W=addu $3,$1,$2, AO_W=5, toggle clk -> RD1 (A1=3) =0, W_we=0, retired=0. Release reset -> after 1 edge reg[3]=5, retired=1.
- Write-source selection: lw $8 with DO_W=32'hDEADBEEF and AO_W=32'h1234 -> reg[8]=DEADBEEF. jal with PC8_W=32'h0000300C -> reg[31]=0000300C. ori $9 with AO_W=32'hFFFF -> reg[9]=0000FFFF.
- $0 and non-writing instructions: addu $0 with AO_W=7 -> W_we=0 and RD1(A1=0)=0. sw, beq and bubble 32'h0 leave all registers unchanged; sw and beq bump retired but the bubble does not.
- Bypass: W stage writes $5=32'hA5A5A5A5 with A1=A2=5 in the same cycle -> RD1=RD2=A5A5A5A5 before the edge, and reg[5] holds the same after it.
- Reset mid-operation: reg[4]=1 committed, then pulse reset=0 between clock edges -> RD(A=4)=0 immediately. The following write only takes effect after release.
- Counter wrap: force retired to all-ones through 2^CNT_W-1 consecutive non-bubble instructions (with CNT_W=4 in the bench: 15 instructions) -> the next instruction yields retired=0.
